irq_source_cond: RTL and testbench

IRQ_SOURCE_COND -- requirements
Module: irq_source_cond

---
 rtl/irq_source_cond.sv | 187 ++++++++++++++++++
 tb/tb_irq_source_cond.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_source_cond.sv
// ---------------------------------------------------------------------------
// irq_source_cond
//
// Conditions raw, asynchronous inputs before the interrupt-vector block sees
// them. The block has two paths:
//   * Four push-button levels. Each is synchronised and then debounced. The
//     debounced level only follows the synchronised level after that level
//     has differed from it for DB_CYCLES consecutive cycles.
//   * Three interrupt request lines (uart, eth_1, eth_2). Each is
//     synchronised and rising-edge detected. A detected edge sets a sticky
//     flag, and the flag stays set until software clears it through irq_clr.
//
// Parameters
//   DB_CYCLES  stable cycles required before a debounced button changes
//              (legal range 2 .. 2**CNT_W-1)
//   CNT_W      width of each debounce counter
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   btn_raw        in   4  raw push-button levels
//   uart_int_raw   in   1  raw uart interrupt request
//   eth_1_int_raw  in   1  raw eth_1 interrupt request
//   eth_2_int_raw  in   1  raw eth_2 interrupt request
//   irq_clr        in   3  clear strobes {uart, eth_1, eth_2}
//   btn            out  4  debounced button levels
//   uart_int       out  1  sticky uart interrupt flag
//   eth_1_int      out  1  sticky eth_1 interrupt flag
//   eth_2_int      out  1  sticky eth_2 interrupt flag
// ---------------------------------------------------------------------------
module irq_source_cond #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    input  logic       uart_int_raw,
    input  logic       eth_1_int_raw,
    input  logic       eth_2_int_raw,
    input  logic [2:0] irq_clr,
    output logic [3:0] btn,
    output logic       uart_int,
    output logic       eth_1_int,
    output logic       eth_2_int
);

    // Counter value at which a pending change is committed. The counter
    // counts 0 .. DB_CYCLES-1 while the input is different, and the change
    // is taken on the cycle after it reaches the terminal value. The change
    // therefore lands DB_CYCLES edges after the synchronised level first
    // differs.
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DB_CYCLES - 1);

    localparam int unsigned NUM_BTN = 4;
    localparam int unsigned NUM_IRQ = 3;

    // Interrupt lines are kept in irq_clr bit order: {uart, eth_1, eth_2}.
    logic [NUM_IRQ-1:0] irq_raw;

    assign irq_raw = {uart_int_raw, eth_1_int_raw, eth_2_int_raw};

    // -----------------------------------------------------------------------
    // Synchroniser registers
    // -----------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_s1_q;
    logic [NUM_BTN-1:0] btn_s2_q;
    logic [NUM_IRQ-1:0] irq_s1_q;
    logic [NUM_IRQ-1:0] irq_s2_q;

    // Two-flop synchronisers on every raw input. No other logic reads a raw
    // input or the first stage. Only s2 feeds the debouncers and edge
    // detectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            irq_s1_q <= '0;
            irq_s2_q <= '0;
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            irq_s1_q <= irq_raw;
            irq_s2_q <= irq_s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Button debouncers
    // -----------------------------------------------------------------------
    logic [NUM_BTN-1:0]            stable_q;
    logic [NUM_BTN-1:0]            stable_d;
    logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_BTN-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_BTN-1:0]            btn_differs;
    logic [NUM_BTN-1:0]            btn_terminal;

    assign btn_differs = btn_s2_q ^ stable_q;

    // Terminal-count detect, one bit per button. The test is >= rather than
    // == so that the counter can never run past the terminal value and wrap,
    // even if it somehow held a larger value.
    always_comb begin
        btn_terminal = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            btn_terminal[i] = (cnt_q[i] >= TERM_CNT);
        end
    end

    // Next-state logic for the debouncers. A button that agrees with its
    // stable value clears its counter, so any bounce restarts qualification
    // from zero. A button that disagrees counts up. On the cycle after the
    // counter reaches the terminal value, the new level is committed. Press
    // and release take the same path.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_differs[i]) begin
                if (btn_terminal[i]) begin
                    stable_d[i] = btn_s2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i]    = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt edge detectors and sticky flags
    // -----------------------------------------------------------------------
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] flag_q;
    logic [NUM_IRQ-1:0] flag_d;
    logic [NUM_IRQ-1:0] irq_edge;

    // prev resets to 0. A line that is already high when reset is released
    // is therefore seen as one rising edge.
    assign irq_edge = irq_s2_q & ~prev_q;

    // The set term is ORed in last, so a clear that coincides with a new
    // edge on the same line loses. A clear on a line whose flag is already
    // low has no effect.
    always_comb begin
        flag_d = flag_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_clr[i]) begin
                flag_d[i] = 1'b0;
            end
            if (irq_edge[i]) begin
                flag_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            flag_q <= '0;
        end else begin
            prev_q <= irq_s2_q;
            flag_q <= flag_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign btn       = stable_q;
    assign uart_int  = flag_q[2];
    assign eth_1_int = flag_q[1];
    assign eth_2_int = flag_q[0];

endmodule

// File: tb/tb_irq_source_cond.sv
// ---------------------------------------------------------------------------
// tb_irq_source_cond
//
// Directed self-checking bench for irq_source_cond, with DB_CYCLES = 4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, so they show the state right after that edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irq_source_cond;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       uart_int_raw;
    logic       eth_1_int_raw;
    logic       eth_2_int_raw;
    logic [2:0] irq_clr;
    logic [3:0] btn;
    logic       uart_int;
    logic       eth_1_int;
    logic       eth_2_int;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    irq_source_cond #(
        .DB_CYCLES (DB),
        .CNT_W     (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .uart_int_raw  (uart_int_raw),
        .eth_1_int_raw (eth_1_int_raw),
        .eth_2_int_raw (eth_2_int_raw),
        .irq_clr       (irq_clr),
        .btn           (btn),
        .uart_int      (uart_int),
        .eth_1_int     (eth_1_int),
        .eth_2_int     (eth_2_int)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset state, then 10 idle cycles with every output low.
    task automatic test_reset();
        rst_n         = 1'b0;
        btn_raw       = 4'b0000;
        uart_int_raw  = 1'b0;
        eth_1_int_raw = 1'b0;
        eth_2_int_raw = 1'b0;
        irq_clr       = 3'b000;
        tick(2);
        checks++;
        if ({btn, uart_int, eth_1_int, eth_2_int} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got=%b expected=%b",
                     {btn, uart_int, eth_1_int, eth_2_int}, 7'b0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checks++;
            if ({btn, uart_int, eth_1_int, eth_2_int} !== 7'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got=%b expected=%b",
                         k, {btn, uart_int, eth_1_int, eth_2_int}, 7'b0);
            end
        end
    endtask

    // Press, then release, of button 0. Each change lands on edge 6.
    task automatic test_btn_press();
        logic [3:0] exp;
        btn_raw = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp = (k >= 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (btn !== exp) begin
                errors++;
                $display("[TB] FAIL btn_press edge %0d: got=%b expected=%b", k, btn, exp);
            end
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp = (k >= 6) ? 4'b0000 : 4'b0001;
            checks++;
            if (btn !== exp) begin
                errors++;
                $display("[TB] FAIL btn_release edge %0d: got=%b expected=%b", k, btn, exp);
            end
        end
    endtask

    // Button 2: high 3 cycles, low 1, then high and held. The bounce restarts
    // qualification, so btn[2] rises on edge 6 after the final rise.
    task automatic test_btn_bounce();
        logic [3:0] exp;
        btn_raw = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            checks++;
            if (btn !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL bounce_early edge %0d: got=%b expected=%b", k, btn, 4'b0000);
            end
        end
        btn_raw = 4'b0000;
        tick(1);
        checks++;
        if (btn !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL bounce_low: got=%b expected=%b", btn, 4'b0000);
        end
        btn_raw = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp = (k >= 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (btn !== exp) begin
                errors++;
                $display("[TB] FAIL bounce_final edge %0d: got=%b expected=%b", k, btn, exp);
            end
        end
        btn_raw = 4'b0000;
        tick(6);
        checks++;
        if (btn !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL bounce_release: got=%b expected=%b", btn, 4'b0000);
        end
    endtask

    // One-cycle pulse on eth_1: the flag appears at edge 3, holds, then clears.
    task automatic test_irq_pulse();
        logic [2:0] exp;
        eth_1_int_raw = 1'b1;
        tick(1);
        eth_1_int_raw = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            tick(1);
            exp = (k >= 3) ? 3'b010 : 3'b000;
            checks++;
            if ({uart_int, eth_1_int, eth_2_int} !== exp) begin
                errors++;
                $display("[TB] FAIL pulse_latency edge %0d: got=%b expected=%b",
                         k, {uart_int, eth_1_int, eth_2_int}, exp);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            checks++;
            if ({uart_int, eth_1_int, eth_2_int} !== 3'b010) begin
                errors++;
                $display("[TB] FAIL pulse_hold cycle %0d: got=%b expected=%b",
                         k, {uart_int, eth_1_int, eth_2_int}, 3'b010);
            end
        end
        irq_clr = 3'b010;
        tick(1);
        irq_clr = 3'b000;
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL pulse_clear: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b000);
        end
    endtask

    // Clears aimed at lines whose flags are low must leave the uart flag alone.
    task automatic test_clear_idle();
        uart_int_raw = 1'b1;
        tick(3);
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL idle_clear_set: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b100);
        end
        irq_clr = 3'b011;
        tick(1);
        irq_clr = 3'b000;
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL idle_clear_other: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b100);
        end
        uart_int_raw = 1'b0;
        irq_clr      = 3'b100;
        tick(1);
        irq_clr = 3'b000;
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_clear_uart: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b000);
        end
        tick(3);
    endtask

    // The uart edge and irq_clr[2] arrive on the same edge: set wins.
    task automatic test_set_wins();
        uart_int_raw = 1'b1;
        tick(2);
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL set_wins_pre: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b000);
        end
        irq_clr = 3'b100;
        tick(1);
        irq_clr = 3'b000;
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL set_wins: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b100);
        end
        tick(5);
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL set_wins_hold: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b100);
        end
        uart_int_raw = 1'b0;
        tick(2);
        irq_clr = 3'b100;
        tick(1);
        irq_clr = 3'b000;
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL set_wins_clear: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b000);
        end
    endtask

    // eth_2 is held high for 50 cycles and cleared once after the set. The
    // flag must not set again while the line stays high.
    task automatic test_hold_high();
        eth_2_int_raw = 1'b1;
        tick(2);
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL hold_pre: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b000);
        end
        tick(1);
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL hold_set: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b001);
        end
        irq_clr = 3'b001;
        tick(1);
        irq_clr = 3'b000;
        for (int k = 4; k <= 50; k++) begin
            checks++;
            if ({uart_int, eth_1_int, eth_2_int} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL hold_no_reset cycle %0d: got=%b expected=%b",
                         k, {uart_int, eth_1_int, eth_2_int}, 3'b000);
            end
            tick(1);
        end
        eth_2_int_raw = 1'b0;
        tick(3);
    endtask

    // Reset is asserted with all flags set and the button counters mid-count.
    // With the raw lines still high after release, each flag sets once, at
    // edge 3.
    task automatic test_reset_mid();
        logic [2:0] expf;
        logic [3:0] expb;
        {uart_int_raw, eth_1_int_raw, eth_2_int_raw} = 3'b111;
        tick(3);
        btn_raw = 4'b1111;
        tick(3);
        checks++;
        if ({btn, uart_int, eth_1_int, eth_2_int} !== 7'b0000111) begin
            errors++;
            $display("[TB] FAIL mid_pre: got=%b expected=%b",
                     {btn, uart_int, eth_1_int, eth_2_int}, 7'b0000111);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btn, uart_int, eth_1_int, eth_2_int} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_reset: got=%b expected=%b",
                     {btn, uart_int, eth_1_int, eth_2_int}, 7'b0);
        end
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            expf = (k >= 3) ? 3'b111 : 3'b000;
            expb = (k >= 6) ? 4'b1111 : 4'b0000;
            checks++;
            if ({btn, uart_int, eth_1_int, eth_2_int} !== {expb, expf}) begin
                errors++;
                $display("[TB] FAIL mid_release edge %0d: got=%b expected=%b",
                         k, {btn, uart_int, eth_1_int, eth_2_int}, {expb, expf});
            end
        end
        irq_clr = 3'b111;
        tick(1);
        irq_clr = 3'b000;
        tick(5);
        checks++;
        if ({uart_int, eth_1_int, eth_2_int} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL mid_single_set: got=%b expected=%b",
                     {uart_int, eth_1_int, eth_2_int}, 3'b000);
        end
        {uart_int_raw, eth_1_int_raw, eth_2_int_raw} = 3'b000;
        btn_raw = 4'b0000;
        tick(8);
        checks++;
        if ({btn, uart_int, eth_1_int, eth_2_int} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL mid_final_idle: got=%b expected=%b",
                     {btn, uart_int, eth_1_int, eth_2_int}, 7'b0);
        end
    endtask

    initial begin
        test_reset();
        test_btn_press();
        test_btn_bounce();
        test_irq_pulse();
        test_clear_idle();
        test_set_wins();
        test_hold_high();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound on the run. The directed sequence uses a few hundred
    // cycles, so this only fires if the run stalls.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
